// File: rtl/multi_digit_display.sv
// Registered N-digit driver for active-low 7-segment HEX displays.
// Holds a double-buffered frame of 5-bit character codes and adds per-digit
// blinking, leading-zero suppression and a left-scrolling message mode.
module multi_digit_display #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCROLL_DIV = 12500000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] frameChars,
  input  logic [NUM_DIGITS-1:0]   blinkMask,
  input  logic                    enable,
  input  logic                    suppressZeros,
  input  logic                    scrollEn,
  output logic [7*NUM_DIGITS-1:0] HexOut,
  output logic                    frameValid,
  output logic                    blinkPhase
);

  // Source positions run over the frame followed by an equally long blank gap.
  localparam int SRC_N    = 2 * NUM_DIGITS;
  localparam int BLINK_W  = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int OFF_W    = $clog2(SRC_N);

  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [OFF_W-1:0]    OFF_LAST    = OFF_W'(SRC_N - 1);
  localparam logic [4:0]          BLANK       = 5'd31;

  // Character code to active-low segments {g,f,e,d,c,b,a}; 15..31 are blank.
  function automatic logic [6:0] seg_encode(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'd0:    seg = 7'h40;
      5'd1:    seg = 7'h79;
      5'd2:    seg = 7'h24;
      5'd3:    seg = 7'h30;
      5'd4:    seg = 7'h19;
      5'd5:    seg = 7'h12;
      5'd6:    seg = 7'h02;
      5'd7:    seg = 7'h78;
      5'd8:    seg = 7'h00;
      5'd9:    seg = 7'h18;
      5'd10:   seg = 7'h0E;
      5'd11:   seg = 7'h3F;
      5'd12:   seg = 7'h23;
      5'd13:   seg = 7'h2F;
      5'd14:   seg = 7'h06;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // A code that may be swallowed by the leading-zero run: zero or any blank.
  function automatic logic is_zero_or_blank(input logic [4:0] code);
    return (code == 5'd0) || (code >= 5'd15);
  endfunction

  logic [5*NUM_DIGITS-1:0] frame_p0;
  logic [NUM_DIGITS-1:0]   mask_p0;
  logic [BLINK_W-1:0]      blink_cnt;
  logic [SCROLL_W-1:0]     scroll_cnt;
  logic [OFF_W-1:0]        offset;

  logic [5*NUM_DIGITS-1:0] shown;
  logic                    zero_run;
  logic [OFF_W-1:0]        off_eff;
  int                      src;
  logic [4:0]              code;
  logic [7*NUM_DIGITS-1:0] hex_next;

  // Frame/mask double buffer: captured only on the load strobe.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_p0   <= {NUM_DIGITS{BLANK}};
      mask_p0    <= '0;
      frameValid <= 1'b0;
    end else if (load) begin
      frame_p0   <= frameChars;
      mask_p0    <= blinkMask;
      frameValid <= 1'b1;
    end
  end

  // Free-running blink timer; a load restarts it with the digits visible.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      blink_cnt  <= '0;
      blinkPhase <= 1'b1;
    end else if (load) begin
      blink_cnt  <= '0;
      blinkPhase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt  <= '0;
      blinkPhase <= ~blinkPhase;
    end else begin
      blink_cnt  <= blink_cnt + BLINK_W'(1);
    end
  end

  // Scroll timer and offset; parked at zero whenever scrolling is off.
  always_ff @(posedge clock) begin
    if (!resetn || load || !scrollEn) begin
      scroll_cnt <= '0;
      offset     <= '0;
    end else if (scroll_cnt == SCROLL_LAST) begin
      scroll_cnt <= '0;
      offset     <= (offset == OFF_LAST) ? '0 : offset + OFF_W'(1);
    end else begin
      scroll_cnt <= scroll_cnt + SCROLL_W'(1);
    end
  end

  // Leading-zero suppression on the stored frame, digit 0 always kept.
  always_comb begin
    shown    = frame_p0;
    zero_run = suppressZeros;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (zero_run && is_zero_or_blank(frame_p0[5*i +: 5])) begin
        shown[5*i +: 5] = BLANK;
      end else begin
        zero_run = 1'b0;
      end
    end
  end

  // Map each display position to its scrolled source digit, apply blink
  // and enable, then encode to segments.
  always_comb begin
    hex_next = '1;
    off_eff  = scrollEn ? offset : '0;
    src      = 0;
    code     = BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      src  = (i + SRC_N - int'(off_eff)) % SRC_N;
      code = BLANK;
      for (int s = 0; s < NUM_DIGITS; s++) begin
        if (s == src) begin
          code = (!blinkPhase && mask_p0[s]) ? BLANK : shown[5*s +: 5];
        end
      end
      if (enable) begin
        hex_next[7*i +: 7] = seg_encode(code);
      end
    end
  end

  // Output register driving the pins.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      HexOut <= '1;
    end else begin
      HexOut <= hex_next;
    end
  end

endmodule

// File: doc/multi_digit_display.md
Name: multi_digit_display

Overview:
- Registered N-digit driver for the board's active-low 7-segment HEX displays. Uses the calculator's 5-bit character codes.
- Double-buffers a full frame on a load strobe. Adds per-digit blinking, leading-zero suppression and a left-scrolling message mode.
- Sits between the calculator result/formatting logic and the HEX pins. Replaces the per-digit combinational decoders.

Parameters:
- NUM_DIGITS, 6, number of HEX digits driven (1..8); digit 0 is rightmost (HEX0).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).
- SCROLL_DIV, 12500000, clock cycles per scroll step (>=2).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- load  in  1  one-cycle strobe; captures frameChars and blinkMask.
- frameChars  in  5*NUM_DIGITS  character code for digit i at [5i+4:5i].
- blinkMask  in  NUM_DIGITS  bit i set: frame digit i blinks.
- enable  in  1  0: all segments off.
- suppressZeros  in  1  1: blank leading zeros.
- scrollEn  in  1  1: scroll frame leftward.
- HexOut  out  7*NUM_DIGITS  active-low segments {g..a} for digit i at [7i+6:7i].
- frameValid  out  1  1 once any frame has been loaded since reset.
- blinkPhase  out  1  1 = blinking digits visible, 0 = hidden.

Behaviour:
- Reset applies at any edge with resetn=0, including mid-scroll or mid-blink. Reset values:
  - HexOut all 1s; frameValid 0; blinkPhase 1.
  - Frame register all code 31 (blank); mask register 0.
  - Blink counter 0; scroll counter 0; scroll offset 0.
- Character encoding (active-low), codes 15..31 blank (7'h7F):
  - Digits 0-9: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18.
  - Symbols: 10=F 0E, 11='-' 3F, 12=o 23, 13=r 2F, 14=E 06.
- Load (edge k, load=1):
  - Frame and mask registers take the inputs; frameValid<=1.
  - Blink counter<=0; blinkPhase<=1; scroll counter<=0; offset<=0.
  - Load has priority over a coincident blink toggle or scroll step.
  - Without load, frame inputs are ignored (holding the old frame).
- Latency: HexOut reflects the register state after edge k at edge k+1. This gives two edges from load sampled to new digits on the pins. enable, suppressZeros and scrollEn changes likewise appear one edge later.
- Blink:
  - Counter counts 0..BLINK_DIV-1 continuously, also while enable=0. At BLINK_DIV-1 it wraps to 0 and blinkPhase toggles.
  - While blinkPhase=0, any displayed character whose source frame digit has a set mask bit shows blank.
- Leading-zero suppression (suppressZeros=1):
  - Scan from digit NUM_DIGITS-1 down to digit 1.
  - Codes 0 and 15..31 in the leading run become blank; the first other code ends the run.
  - Digit 0 is never suppressed.
  - Applied to the frame before scrolling.
- Scroll:
  - scrollEn=0: offset and scroll counter are held at 0.
  - scrollEn=1: counter counts 0..SCROLL_DIV-1; on wrap, offset<=(offset+1) mod 2*NUM_DIGITS.
  - Display digit i shows source index s=(i-offset) mod 2*NUM_DIGITS. For s<NUM_DIGITS it shows frame digit s (after suppression); for s>=NUM_DIGITS it shows blank.
  - Content thus moves one position left per step, scrolls fully off, then re-enters from the right.
- enable=0 overrides everything (all 1s). Internal state is retained, so re-enable shows the current frame, phase and offset.
- Simultaneous blink wrap and scroll wrap on the same edge: both take effect.

Test Plan:
- Reset, release, no load → HexOut=all 7'h7F indefinitely; frameValid=0; blinkPhase=1.
- NUM_DIGITS=6: load codes {d5..d0}={31,31,11,1,2,3}, enable=1 → two edges later HexOut digits = 7F,7F,3F,79,24,30; frameValid=1.
- Load {0,0,0,4,0,7}, suppressZeros=1 → 7F,7F,7F,19,40,78. Load all zeros → only digit 0 shows 40.
- BLINK_DIV=4, mask=6'b000001, frame 8s → digit 0 alternates 00/7F every 4 cycles; other digits steady 00. Load at a wrap cycle → phase stays 1 and the counter restarts.
- SCROLL_DIV=2, frame {31,31,31,31,1,2}, scrollEn=1 → after each step digits 2,1 show 79,24 one position further left. After 12 steps (offset back to 0) the original pattern is shown. scrollEn=0 → immediate return to offset 0.
- Assert resetn=0 for one edge mid-scroll with enable=1 → next edge HexOut all 7F, frameValid=0, offset 0. enable=0 then 1 → blank then the current frame again.
